// File: rtl/adc_capture_scheduler.sv
// Paces conversion requests to an SPI ADC read engine, collects a fixed number of
// samples into a shift buffer and tracks the largest one, flagging timeouts and late replies.
module adc_capture_scheduler #(
  parameter int NUM_SAMPLES = 10,
  parameter int SAMPLE_W    = 12,
  parameter int INTERVAL    = 500,
  parameter int TIMEOUT     = 2000
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            abort,
  output logic                            conv_req,
  input  logic                            conv_done,
  input  logic [SAMPLE_W-1:0]             sample,
  output logic                            busy,
  output logic                            done,
  output logic                            err,
  output logic                            overrun,
  output logic [3:0]                      count,
  output logic [SAMPLE_W-1:0]             sample_max,
  output logic [NUM_SAMPLES*SAMPLE_W-1:0] storage
);

  localparam int STORE_W = NUM_SAMPLES * SAMPLE_W;
  localparam int TCNT_W  = $clog2(TIMEOUT + 1);

  localparam logic [TCNT_W-1:0] TICK_EARLY = TCNT_W'(INTERVAL - 2);
  localparam logic [TCNT_W-1:0] TICK_LAST  = TCNT_W'(INTERVAL - 1);
  localparam logic [TCNT_W-1:0] TMO_LAST   = TCNT_W'(TIMEOUT - 1);
  localparam logic [3:0]        FULL_COUNT = 4'(NUM_SAMPLES);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT_DONE,
    WAIT_TICK,
    DONE
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [TCNT_W-1:0]   tcnt;
  logic [3:0]          count_inc;
  logic                capture;
  logic                clear;
  logic                set_err;
  logic                set_ovr;

  function automatic logic [SAMPLE_W-1:0] max_u(input logic [SAMPLE_W-1:0] a,
                                                 input logic [SAMPLE_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

  function automatic logic [STORE_W-1:0] shift_in(input logic [STORE_W-1:0]  buf_in,
                                                  input logic [SAMPLE_W-1:0] s);
    return (buf_in << SAMPLE_W) | STORE_W'(s);
  endfunction

  assign count_inc = count + 4'd1;
  assign conv_req  = (state == REQ);
  assign done      = (state == DONE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    clear     = 1'b0;
    set_err   = 1'b0;
    set_ovr   = 1'b0;
    case (state)
      IDLE: begin
        // start together with abort is treated as no request at all
        if (start && !abort) begin
          state_nxt = REQ;
          clear     = 1'b1;
        end
      end
      REQ: begin
        state_nxt = abort ? IDLE : WAIT_DONE;
      end
      WAIT_DONE: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (conv_done) begin
          capture = 1'b1;
          if (count_inc == FULL_COUNT) begin
            state_nxt = DONE;
          end else if (tcnt <= TICK_EARLY) begin
            state_nxt = WAIT_TICK;
          end else if (tcnt == TICK_LAST) begin
            state_nxt = REQ;
          end else begin
            state_nxt = REQ;
            set_ovr   = 1'b1;
          end
        end else if (tcnt == TMO_LAST) begin
          state_nxt = DONE;
          set_err   = 1'b1;
        end
      end
      WAIT_TICK: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tcnt == TICK_LAST) begin
          state_nxt = REQ;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // tcnt is zero during every REQ cycle, so it measures clocks since the last request
  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      tcnt       <= '0;
      storage    <= '0;
      count      <= '0;
      sample_max <= '0;
      err        <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt == REQ || state_nxt == IDLE) begin
        tcnt <= '0;
      end else begin
        tcnt <= tcnt + 1'b1;
      end
      if (clear) begin
        storage    <= '0;
        count      <= '0;
        sample_max <= '0;
        err        <= 1'b0;
        overrun    <= 1'b0;
      end else begin
        if (capture) begin
          storage    <= shift_in(storage, sample);
          count      <= count_inc;
          sample_max <= max_u(sample_max, sample);
        end
        if (set_err) begin
          err <= 1'b1;
        end
        if (set_ovr) begin
          overrun <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_adc_capture_scheduler.sv
// Directed bench for adc_capture_scheduler with 3 samples, 8-clock interval, 20-clock timeout.
module tb_adc_capture_scheduler;

  localparam int NS = 3;
  localparam int SW = 12;
  localparam int IV = 8;
  localparam int TO = 20;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          abort;
  logic          conv_req;
  logic          conv_done;
  logic [SW-1:0] sample;
  logic          busy;
  logic          done;
  logic          err;
  logic          overrun;
  logic [3:0]    count;
  logic [SW-1:0] sample_max;
  logic [NS*SW-1:0] storage;

  int tests = 0;
  int failed = 0;
  int cyc = 0;
  int req_pulses = 0;
  int done_pulses = 0;
  int r1, r2, r3;
  int snap_req, snap_done;

  adc_capture_scheduler #(
    .NUM_SAMPLES(NS),
    .SAMPLE_W   (SW),
    .INTERVAL   (IV),
    .TIMEOUT    (TO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .abort     (abort),
    .conv_req  (conv_req),
    .conv_done (conv_done),
    .sample    (sample),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .overrun   (overrun),
    .count     (count),
    .sample_max(sample_max),
    .storage   (storage)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (conv_req) req_pulses++;
    if (done) done_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int dly, input logic [SW-1:0] v);
    repeat (dly) step();
    conv_done = 1'b1;
    sample    = v;
    step();
    conv_done = 1'b0;
    sample    = '0;
  endtask

  task automatic wait_req(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step();
      if (conv_req) found = 1'b1;
    end
    chk(tag, 64'(found), 64'd1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; abort = 1'b0; conv_done = 1'b0; sample = '0;
    step(); step();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req", 64'(conv_req), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_storage", 64'(storage), 64'd0);
    chk("rst_max", 64'(sample_max), 64'd0);
    chk("rst_flags", {62'd0, err, overrun}, 64'd0);
    rst = 1'b1;
    step();

    // Normal capture
    start = 1'b1; step(); start = 1'b0;
    chk("norm_req1", 64'(conv_req), 64'd1);
    chk("norm_busy", 64'(busy), 64'd1);
    r1 = cyc;
    send(3, 12'h100);
    chk("norm_cnt1", 64'(count), 64'd1);
    chk("norm_tick_noreq", 64'(conv_req), 64'd0);
    wait_req("norm_wait2", 12);
    r2 = cyc;
    chk("norm_period1", 64'(r2 - r1), 64'd8);
    send(3, 12'hABC);
    wait_req("norm_wait3", 12);
    r3 = cyc;
    chk("norm_period2", 64'(r3 - r2), 64'd8);
    send(3, 12'h005);
    chk("norm_done", 64'(done), 64'd1);
    chk("norm_count", 64'(count), 64'd3);
    chk("norm_storage", 64'(storage), 64'h100ABC005);
    chk("norm_max", 64'(sample_max), 64'hABC);
    chk("norm_flags", {62'd0, err, overrun}, 64'd0);
    step();
    chk("norm_idle_busy", 64'(busy), 64'd0);
    chk("norm_done_once", 64'(done), 64'd0);
    chk("norm_hold_storage", 64'(storage), 64'h100ABC005);
    chk("norm_req_total", 64'(req_pulses), 64'd3);

    // Late conversion
    start = 1'b1; step(); start = 1'b0;
    chk("late_clear_storage", 64'(storage), 64'd0);
    chk("late_clear_count", 64'(count), 64'd0);
    chk("late_clear_max", 64'(sample_max), 64'd0);
    send(3, 12'h010);
    wait_req("late_wait2", 12);
    send(10, 12'h020);
    chk("late_req_next", 64'(conv_req), 64'd1);
    chk("late_overrun", 64'(overrun), 64'd1);
    send(3, 12'h030);
    chk("late_done", 64'(done), 64'd1);
    chk("late_count", 64'(count), 64'd3);
    chk("late_storage", 64'(storage), 64'h010020030);
    chk("late_max", 64'(sample_max), 64'h030);
    chk("late_err", 64'(err), 64'd0);
    step();

    // Timeout
    start = 1'b1; step(); start = 1'b0;
    r1 = cyc;
    chk("tmo_clear_ovr", 64'(overrun), 64'd0);
    chk("tmo_req", 64'(conv_req), 64'd1);
    step();
    snap_req = req_pulses;
    repeat (18) step();
    chk("tmo_not_yet", 64'(done), 64'd0);
    chk("tmo_busy", 64'(busy), 64'd1);
    step();
    chk("tmo_latency", 64'(cyc - r1), 64'd20);
    chk("tmo_done", 64'(done), 64'd1);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_count", 64'(count), 64'd0);
    repeat (5) step();
    chk("tmo_no_req", 64'(req_pulses), 64'(snap_req));
    chk("tmo_err_sticky", 64'(err), 64'd1);

    // Restart clears, then abort on the second sample
    start = 1'b1; step(); start = 1'b0;
    chk("rs_err", 64'(err), 64'd0);
    chk("rs_ovr", 64'(overrun), 64'd0);
    chk("rs_count", 64'(count), 64'd0);
    chk("rs_storage", 64'(storage), 64'd0);
    chk("rs_req", 64'(conv_req), 64'd1);
    send(3, 12'h111);
    wait_req("ab_wait2", 12);
    repeat (3) step();
    conv_done = 1'b1; sample = 12'h222; abort = 1'b1;
    step();
    conv_done = 1'b0; sample = '0; abort = 1'b0;
    snap_req = req_pulses;
    snap_done = done_pulses;
    chk("ab_busy", 64'(busy), 64'd0);
    chk("ab_count", 64'(count), 64'd1);
    chk("ab_storage", 64'(storage), 64'h111);
    chk("ab_max", 64'(sample_max), 64'h111);
    repeat (10) step();
    chk("ab_no_req", 64'(req_pulses), 64'(snap_req));
    chk("ab_no_done", 64'(done_pulses), 64'(snap_done));

    // Ignored inputs in IDLE
    conv_done = 1'b1; sample = 12'hFFF; step(); conv_done = 1'b0; sample = '0;
    chk("idle_done_ign_cnt", 64'(count), 64'd1);
    chk("idle_done_ign_max", 64'(sample_max), 64'h111);
    start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
    chk("sa_busy", 64'(busy), 64'd0);
    chk("sa_no_clear", 64'(count), 64'd1);

    // Start while busy, then reset during WAIT_TICK
    start = 1'b1; step(); start = 1'b0;
    r1 = cyc;
    send(3, 12'h050);
    start = 1'b1; step(); start = 1'b0;
    chk("busy_start_cnt", 64'(count), 64'd1);
    chk("busy_start_noreq", 64'(conv_req), 64'd0);
    chk("busy_start_storage", 64'(storage), 64'h050);
    wait_req("busy_wait2", 12);
    chk("busy_period", 64'(cyc - r1), 64'd8);
    send(3, 12'h060);
    chk("pre_rst_cnt", 64'(count), 64'd2);
    rst = 1'b0; step(); rst = 1'b1;
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_req", 64'(conv_req), 64'd0);
    chk("mid_rst_count", 64'(count), 64'd0);
    chk("mid_rst_storage", 64'(storage), 64'd0);
    chk("mid_rst_max", 64'(sample_max), 64'd0);
    chk("mid_rst_flags", {62'd0, err, overrun, done}, 64'd0);
    step();
    chk("post_rst_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/adc_capture_scheduler.md
Name: adc_capture_scheduler

Overview:
- Sequences a 12-bit SPI ADC reader (MIKROE-340 path): issues one conversion request every INTERVAL clocks and captures NUM_SAMPLES results into a shift buffer.
- Tracks a running maximum and reports done, error (conversion timeout) and overrun (late conversion).
- Sits between the system-level capture logic (start/abort) and the ADC read engine (conv_req/conv_done/sample).

Parameters:
- NUM_SAMPLES, 10, samples per capture (1..15).
- SAMPLE_W, 12, ADC sample width.
- INTERVAL, 500, nominal clocks between consecutive conv_req pulses (>=2).
- TIMEOUT, 2000, clocks after conv_req without conv_done before error (>INTERVAL).

Ports:
- clk  in  1  50 MHz system clock.
- rst  in  1  synchronous, active-low reset.
- start  in  1  begin capture; accepted only in IDLE.
- abort  in  1  cancel capture; highest priority after reset.
- conv_req  out  1  one-cycle pulse; request one ADC conversion.
- conv_done  in  1  one-cycle pulse; sample valid this cycle.
- sample  in  SAMPLE_W  ADC result, qualified by conv_done.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at capture end (normal or timeout).
- err  out  1  sticky timeout flag; cleared on next accepted start.
- overrun  out  1  sticky late-conversion flag; cleared on next accepted start.
- count  out  4  samples stored in the current capture.
- sample_max  out  SAMPLE_W  largest sample of the current capture.
- storage  out  NUM_SAMPLES*SAMPLE_W  newest sample in [SAMPLE_W-1:0], older samples shifted up.

Behaviour:
- Reset (rst==0 at posedge): state IDLE; every output and every internal counter is 0.
- States: IDLE, REQ, WAIT_DONE, WAIT_TICK, DONE. There is one counter, tcnt, sized to hold TIMEOUT.
- IDLE:
  - start=1 and abort=0 → REQ.
  - On that same edge, storage, count, sample_max, err and overrun clear to 0.
  - start is ignored in every other state.
- REQ:
  - conv_req=1 for this cycle only; tcnt=0 in this cycle.
  - Next state is WAIT_DONE.
  - Result: start sampled at edge N gives conv_req high in cycle N+1.
- tcnt increments by 1 every cycle outside REQ and IDLE.
- WAIT_DONE, on conv_done=1:
  - storage shifts left by SAMPLE_W and sample loads the LSBs.
  - count increments by 1.
  - sample_max updates to max(sample_max, sample), unsigned compare.
  - All captured values are visible in the next cycle.
  - If the new count equals NUM_SAMPLES → DONE.
  - Else if tcnt <= INTERVAL-2 → WAIT_TICK.
  - Else if tcnt == INTERVAL-1 → REQ, on time.
  - Else (tcnt >= INTERVAL) → REQ and set overrun=1.
- WAIT_DONE, no conv_done while tcnt == TIMEOUT-1: set err=1 → DONE.
- WAIT_TICK:
  - tcnt == INTERVAL-1 → REQ, so the req-to-req period is exactly INTERVAL clocks.
  - conv_done here is ignored; no capture.
- DONE: done=1 for one cycle → IDLE. storage, count, sample_max and flags hold until the next accepted start.
- abort=1 in any non-IDLE state:
  - Next state IDLE, with no done pulse and no conv_req.
  - A conv_done in the same cycle is discarded.
  - Captured data is retained.
- conv_done in IDLE, REQ or DONE is ignored.
- A start/abort in the same cycle while IDLE leaves the block in IDLE with no clear.
- Reset mid-capture: all state and outputs return to reset values on that edge.

Test Plan (bench params NUM_SAMPLES=3, INTERVAL=8, TIMEOUT=20):
- Normal capture: start at cycle 0; reply conv_done 3 cycles after each conv_req with samples 0x100, 0xABC, 0x005 → conv_req at cycles 1, 9, 17; done pulse after the third sample; storage[35:0]=0x100ABC005; count=3; sample_max=0xABC; err=0; overrun=0.
- Late conversion: conv_done 10 cycles after the second conv_req → third conv_req comes 1 cycle after that conv_done; overrun=1; done still pulses; count=3.
- Timeout: no conv_done after the first conv_req → done pulses 20 cycles after conv_req; err=1; count=0; no further conv_req.
- Abort: abort asserted in the same cycle as the second conv_done → next cycle IDLE; busy=0; count=1; no done pulse; no more conv_req.
- Restart clears state: start after the timeout case → err=0, overrun=0, count=0, storage=0 on the accepting edge; new conv_req next cycle.
- Reset and ignored inputs: rst=0 during WAIT_TICK → all outputs 0 next cycle. A start pulse while busy produces no extra conv_req and no clear.
